// File: rtl/seq_tx.sv
// seq_tx: serialises an LSB-aligned pattern MSB-first, then idles for GAP cycles.
// Define SEQ_TX_PARITY_EN to append an even-parity bit (state PAR) after the data bits.
module seq_tx #(
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         data,
    input  logic [$clog2(W):0]   len,
    input  logic                 abort,
    output logic                 x,
    output logic                 x_vld,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(W) + 1;
    localparam int IW = $clog2(W);
    localparam int GW = $clog2(GAP + 1);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_PAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

    state_t          state, state_n;
    logic [W-1:0]    sr, sr_n;
    logic [CW-1:0]   cnt, cnt_n, len_c;
    logic [GW-1:0]   gcnt, gcnt_n;
    logic            x_n, x_vld_n, done_n;
`ifdef SEQ_TX_PARITY_EN
    logic            par, par_n;
`endif

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        x_n     = 1'b0;
        x_vld_n = 1'b0;
        done_n  = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_n   = par;
`endif
        len_c   = (len > CW'(W)) ? CW'(W) : len;

        case (state)
            ST_IDLE: begin
                if (in_valid && !abort) begin
                    sr_n = data;
                    if (len_c == '0) begin
                        // Zero-length frame goes straight to the gap.
                        state_n = ST_GAP;
                        done_n  = 1'b1;
                        gcnt_n  = GW'(GAP - 1);
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_SHIFT;
                        x_n     = data[IW'(len_c - 1'b1)];
                        x_vld_n = 1'b1;
                        cnt_n   = len_c - 1'b1;
`ifdef SEQ_TX_PARITY_EN
                        par_n   = data[IW'(len_c - 1'b1)];
`endif
                    end
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    x_n     = sr[IW'(cnt - 1'b1)];
                    x_vld_n = 1'b1;
                    cnt_n   = cnt - 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    par_n   = par ^ sr[IW'(cnt - 1'b1)];
`endif
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_n = ST_PAR;
                    x_n     = par;
                    x_vld_n = 1'b1;
`else
                    state_n = ST_GAP;
                    done_n  = 1'b1;
                    gcnt_n  = GW'(GAP - 1);
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                    done_n  = 1'b1;
                    gcnt_n  = GW'(GAP - 1);
                end
            end
`endif
            ST_GAP: begin
                if (gcnt == '0) state_n = ST_IDLE;
                else            gcnt_n  = gcnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            x     <= 1'b0;
            x_vld <= 1'b0;
            done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
            x     <= x_n;
            x_vld <= x_vld_n;
            done  <= done_n;
`ifdef SEQ_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx (W=8, GAP=2); expected per-cycle outputs are queued
// when a frame is offered and compared cycle by cycle against the DUT.
module tb_seq_tx;

    localparam int W   = 8;
    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data;
    logic [3:0]   len;
    logic         abort;
    logic         x, x_vld, done, busy;

    typedef struct packed {
        logic x;
        logic vld;
        logic done;
        logic rdy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    seq_tx #(.W(W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .len(len), .abort(abort),
        .x(x), .x_vld(x_vld), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    // Expected outputs for cycles 1.. after an accept edge, ending with the in_ready cycle.
    function automatic void push_frame(input logic [W-1:0] d, input int l);
        int   lc;
        logic p;
        exp_t e;
        lc = (l > W) ? W : l;
        p  = 1'b0;
        for (int i = lc - 1; i >= 0; i--) begin
            e = '{x: d[i], vld: 1'b1, done: 1'b0, rdy: 1'b0};
            p = p ^ d[i];
            sb.push_back(e);
        end
        if (PAR_ON && lc > 0) sb.push_back('{x: p, vld: 1'b1, done: 1'b0, rdy: 1'b0});
        for (int g = 0; g < GAP; g++)
            sb.push_back('{x: 1'b0, vld: 1'b0, done: (g == 0), rdy: 1'b0});
        sb.push_back('{x: 1'b0, vld: 1'b0, done: 1'b0, rdy: 1'b1});
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; data = 8'hFF; len = 4'd8; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({x, x_vld, done, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got x/vld/done/busy=%b required 0000", {x, x_vld, done, busy});
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_frame(input string name, input logic [W-1:0] d, input logic [3:0] l);
        exp_t e;
        int   c;
        push_frame(d, int'(l));
        @(negedge clk);
        in_valid = 1'b1; data = d; len = l;
        c = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            c++;
            e = sb.pop_front();
            n_chk++;
            if ({x, x_vld, done, in_ready, busy} !== {e.x, e.vld, e.done, e.rdy, ~e.rdy}) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got x/vld/done/rdy/busy=%b required %b", name, c,
                         {x, x_vld, done, in_ready, busy}, {e.x, e.vld, e.done, e.rdy, ~e.rdy});
            end
            in_valid = 1'b0;
            data = ~d;
        end
    endtask

    task automatic test_abort();
        exp_t e;
        push_frame(8'hFF, 8);
        while (sb.size() > 3) void'(sb.pop_back());
        repeat (4) sb.push_back('{x: 1'b0, vld: 1'b0, done: 1'b0, rdy: 1'b1});
        @(negedge clk);
        in_valid = 1'b1; data = 8'hFF; len = 4'd8;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if ({x, x_vld, done, in_ready, busy} !== {e.x, e.vld, e.done, e.rdy, ~e.rdy}) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got x/vld/done/rdy/busy=%b required %b", c,
                         {x, x_vld, done, in_ready, busy}, {e.x, e.vld, e.done, e.rdy, ~e.rdy});
            end
            in_valid = 1'b0;
            abort = (c == 3);
        end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   total;
        push_frame(8'h02, 2);
        push_frame(8'h01, 2);
        total = sb.size();
        @(negedge clk);
        in_valid = 1'b1; data = 8'h02; len = 4'd2;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if ({x, x_vld, done, in_ready, busy} !== {e.x, e.vld, e.done, e.rdy, ~e.rdy}) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got x/vld/done/rdy/busy=%b required %b", c,
                         {x, x_vld, done, in_ready, busy}, {e.x, e.vld, e.done, e.rdy, ~e.rdy});
            end
            data = 8'h01;
            if (c == total) in_valid = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        push_frame(8'hAA, 8);
        while (sb.size() > 2) void'(sb.pop_back());
        repeat (2) sb.push_back('{x: 1'b0, vld: 1'b0, done: 1'b0, rdy: 1'b1});
        @(negedge clk);
        in_valid = 1'b1; data = 8'hAA; len = 4'd8;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if ({x, x_vld, done, in_ready, busy} !== {e.x, e.vld, e.done, e.rdy, ~e.rdy}) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got x/vld/done/rdy/busy=%b required %b", c,
                         {x, x_vld, done, in_ready, busy}, {e.x, e.vld, e.done, e.rdy, ~e.rdy});
            end
            in_valid = 1'b0;
            rst = (c == 2);
        end
        rst = 1'b0;
        test_frame("after_reset", 8'h0B, 4'd4);
    endtask

    initial begin
        test_reset();
        test_frame("normal", 8'h0B, 4'd4);
        test_frame("clamp", 8'hA5, 4'd12);
        test_frame("zero_len", 8'hFF, 4'd0);
        test_frame("full_len", 8'h3C, 4'd8);
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter W, default 8, meaning maximum pattern length in bits (range 2..16).
REQ-002 Parameter GAP, default 2, meaning idle cycles inserted after each frame (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  pattern offered.
REQ-006 in_ready  output  1  block can accept a pattern.
REQ-007 data  input  W  pattern bits, LSB-aligned.
REQ-008 len  input  clog2(W)+1  number of bits to send.
REQ-009 abort  input  1  cancel the frame in progress.
REQ-010 x  output  1  serial bit stream, registered.
REQ-011 x_vld  output  1  x carries a frame bit this cycle, registered.
REQ-012 done  output  1  one-cycle pulse on normal frame completion.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and GAP, plus PAR when parity is compiled in (REQ-029).
REQ-015 in_ready SHALL equal 1 only in IDLE, and a pattern SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and abort=0.
REQ-016 On accept, data SHALL be latched into a shift register and the length into a bit counter.
REQ-017 A len value greater than W SHALL be clamped to W.
REQ-018 Bit order SHALL be data[len-1] first, down to data[0] last.
REQ-019 If the accept edge is cycle 0, frame bits SHALL appear on x with x_vld=1 in cycles 1..L, where L is the clamped length, with no gaps.
REQ-020 After the last bit, the FSM SHALL enter GAP for exactly GAP cycles with x_vld=0 and x=0, then return to IDLE.
REQ-021 done SHALL pulse high in the first GAP cycle only, i.e. cycle L+1 (cycle L+2 with parity).
REQ-022 in_ready SHALL return to 1 in cycle L+GAP+1 (cycle L+GAP+2 with parity).
REQ-023 len=0 SHALL be accepted, send no bits (x_vld stays 0), go directly to GAP, and pulse done in cycle 1.
REQ-024 Whenever x_vld=0, x SHALL be 0.
REQ-025 abort=1 sampled in SHIFT or PAR SHALL force x_vld=0 and state IDLE on the next cycle, with no done pulse and no GAP.
REQ-026 abort=1 sampled in GAP or IDLE SHALL have no effect, except that in IDLE it blocks acceptance.
REQ-027 in_valid held high while busy SHALL be ignored, and data/len changes while busy SHALL NOT affect the frame in progress.

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be IDLE with x=0, x_vld=0, done=0, busy=0, and shift register and counter cleared; in_ready SHALL be 1 in the cycle after reset is released. Reset applied mid-frame SHALL truncate the frame immediately with no done pulse; rst SHALL take priority over abort and in_valid.

Configuration
REQ-029 With macro SEQ_TX_PARITY_EN defined, the FSM SHALL pass through state PAR for one cycle after the last data bit, driving x = XOR of the L sent bits (even parity) with x_vld=1, before entering GAP. With len=0, PAR SHALL be skipped.
REQ-030 Without SEQ_TX_PARITY_EN, the PAR state and its logic SHALL be absent and frames SHALL be L bits long.

Verification
REQ-031 Normal frame, W=8, GAP=2: data=8'h0B, len=4, accept cycle 0 -> x=1,0,1,1 in cycles 1-4 with x_vld=1; done only in cycle 5; in_ready=1 in cycle 7.
REQ-032 Parity build: data=8'h0B, len=4 -> x=1,0,1,1,1 in cycles 1-5; done in cycle 6; in_ready=1 in cycle 8.
REQ-033 Abort: data=8'hFF, len=8, abort=1 sampled at the edge ending cycle 3 -> x_vld=0 and in_ready=1 from cycle 4; done never pulses.
REQ-034 Clamp and zero length: len=12, data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; len=0 -> no x_vld, done in cycle 1, in_ready=1 in cycle 3.
REQ-035 Back-to-back and busy: in_valid held high with len=2 -> second accept occurs in cycle L+GAP+1=5, never earlier; data changed mid-frame does not alter the bits sent.
REQ-036 Reset mid-frame: rst=1 sampled during cycle 2 of an 8-bit frame -> x=0, x_vld=0, busy=0 from cycle 3; no done pulse; a new frame is accepted normally after rst drops.
